// File: rtl/multdiv_sequencer.sv
// rtl/multdiv_sequencer.sv - iterative signed 32-bit multiply/divide sequencer driving a shared external ALU
module multdiv_sequencer #(
    parameter int N_STEPS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy,
    output logic [31:0] alu_operandA,
    output logic [31:0] alu_operandB,
    output logic [4:0]  alu_opcode,
    output logic [4:0]  alu_shiftamt,
    input  logic [31:0] alu_result,
    input  logic        alu_overflow
);

    localparam int CW = $clog2(N_STEPS);
    localparam logic [CW-1:0] LAST_STEP = CW'(N_STEPS - 1);
    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MSTEP,
        S_DNEG_A,
        S_DNEG_B,
        S_DSTEP,
        S_DFIX,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    // acc holds the Booth high word during MULT and the partial remainder during DIV
    logic [31:0]    acc_q, acc_d;
    // q holds the Booth multiplier/low word during MULT and the dividend/quotient during DIV
    logic [31:0]    q_q, q_d;
    logic           q1_q, q1_d;
    // m holds the multiplicand during MULT and the divisor magnitude during DIV
    logic [31:0]    m_q, m_d;
    logic           neg_q, neg_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    result_q, result_d;
    logic           exc_q, exc_d;

    logic [31:0]    rs;
    logic           borrow;
    logic           sign_fix;

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (state_q == S_DONE);
    assign busy           = (state_q != S_IDLE);
    assign alu_shiftamt   = 5'd0;

    // Next-state, datapath update and ALU request for the current step
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        q_d          = q_q;
        q1_d         = q1_q;
        m_d          = m_q;
        neg_d        = neg_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        exc_d        = exc_q;
        alu_operandA = 32'd0;
        alu_operandB = 32'd0;
        alu_opcode   = OP_ADD;

        rs       = {acc_q[30:0], q_q[31]};
        sign_fix = alu_result[31] ^ alu_overflow;
        borrow   = (~rs[31] & m_q[31]) | (~(rs[31] ^ m_q[31]) & alu_result[31]);

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (ctrl_MULT) begin
                    acc_d   = 32'd0;
                    q_d     = data_operandB;
                    q1_d    = 1'b0;
                    m_d     = data_operandA;
                    cnt_d   = '0;
                    state_d = S_MSTEP;
                end else if (ctrl_DIV) begin
                    if ((data_operandB == 32'd0) ||
                        ((data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF))) begin
                        result_d = 32'd0;
                        exc_d    = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        q_d     = data_operandA;
                        m_d     = data_operandB;
                        neg_d   = data_operandA[31] ^ data_operandB[31];
                        state_d = S_DNEG_A;
                    end
                end
            end
            S_MSTEP: begin
                alu_operandA = acc_q;
                case ({q_q[0], q1_q})
                    2'b01: begin
                        alu_operandB = m_q;
                        alu_opcode   = OP_ADD;
                    end
                    2'b10: begin
                        alu_operandB = m_q;
                        alu_opcode   = OP_SUB;
                    end
                    default: begin
                        alu_operandB = 32'd0;
                        alu_opcode   = OP_ADD;
                    end
                endcase
                // Arithmetic right shift of {hi,Q,q_1}; sign taken from the true 33-bit sum
                acc_d = {sign_fix, alu_result[31:1]};
                q_d   = {alu_result[0], q_q[31:1]};
                q1_d  = q_q[0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    result_d = q_d;
                    exc_d    = (acc_d != {32{q_d[31]}});
                    state_d  = S_DONE;
                end
            end
            S_DNEG_A: begin
                alu_operandB = q_q;
                alu_opcode   = OP_SUB;
                q_d          = q_q[31] ? alu_result : q_q;
                state_d      = S_DNEG_B;
            end
            S_DNEG_B: begin
                alu_operandB = m_q;
                alu_opcode   = OP_SUB;
                m_d          = m_q[31] ? alu_result : m_q;
                acc_d        = 32'd0;
                cnt_d        = '0;
                state_d      = S_DSTEP;
            end
            S_DSTEP: begin
                alu_operandA = rs;
                alu_operandB = m_q;
                alu_opcode   = OP_SUB;
                // Restore on borrow, otherwise keep the difference and shift in a 1
                if (borrow) begin
                    acc_d = rs;
                    q_d   = {q_q[30:0], 1'b0};
                end else begin
                    acc_d = alu_result;
                    q_d   = {q_q[30:0], 1'b1};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DFIX;
                end
            end
            S_DFIX: begin
                alu_operandB = q_q;
                alu_opcode   = OP_SUB;
                result_d     = neg_q ? alu_result : q_q;
                exc_d        = 1'b0;
                state_d      = S_DONE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            acc_q    <= 32'd0;
            q_q      <= 32'd0;
            q1_q     <= 1'b0;
            m_q      <= 32'd0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= 32'd0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            q_q      <= q_d;
            q1_q     <= q1_d;
            m_q      <= m_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
- Iterative signed 32-bit multiply/divide controller for the processor's execute stage.
- Owns no adder: every add, subtract and negate is issued to an external shared 32-bit ALU instance (combinational, add opcode 5'b00000, sub 5'b00001), and the ALU result is captured each cycle.
- Multiply uses radix-2 Booth. Divide uses unsigned restoring division on magnitudes, followed by a sign fix.

Parameters:
- N_STEPS, 32, iteration count for both operations; must equal the operand width.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- data_operandA  in  32  multiplicand / dividend, sampled on the accepted ctrl cycle
- data_operandB  in  32  multiplier / divisor, sampled on the accepted ctrl cycle
- ctrl_MULT  in  1  one-cycle start pulse, multiply
- ctrl_DIV  in  1  one-cycle start pulse, divide
- data_result  out  32  product low word or quotient
- data_exception  out  1  overflow or divide-by-zero flag for the current result
- data_resultRDY  out  1  one-cycle pulse; result and exception valid
- busy  out  1  high from the cycle after acceptance through the DONE cycle
- alu_operandA  out  32  to shared ALU
- alu_operandB  out  32  to shared ALU
- alu_opcode  out  5  to shared ALU
- alu_shiftamt  out  5  to shared ALU; always 0
- alu_result  in  32  from shared ALU
- alu_overflow  in  1  from shared ALU

Behaviour:
- Reset: state IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0; alu_* outputs all 0 (opcode add). Reset wins over any in-flight operation; no resultRDY is produced for an aborted operation.
- Acceptance: a start is accepted only in IDLE or DONE. If ctrl_MULT and ctrl_DIV are both high, MULT is accepted. Starts arriving in any other state are ignored.
- States: IDLE, MSTEP, DNEG_A, DNEG_B, DSTEP, DFIX, DONE. DONE lasts one cycle, asserts data_resultRDY, then goes to IDLE unless a new start is accepted in the same cycle.
- data_result and data_exception update only on entry to DONE, and hold until the next DONE.
- MULT, accepted at cycle N:
  - Load hi=0, Q=B, q_1=0, M=A. MSTEP runs for N_STEPS cycles (N+1..N+32). DONE is at N+33.
  - Each MSTEP cycle drives alu_operandA=hi and selects on {Q[0],q_1}:
    - 01: alu_operandB=M, add.
    - 10: alu_operandB=M, sub.
    - 00 or 11: alu_operandB=0, add.
  - Register update: {hi,Q,q_1} <= {s, alu_result, Q}, where s = alu_result[31] XOR alu_overflow. This is the arithmetic right shift by 1 with overflow-corrected sign.
  - Final result: data_result = Q. data_exception = 1 iff hi is not all equal to Q[31].
- DIV, accepted at cycle N:
  - If B==0: go directly to DONE at N+1 with result=0, exception=1.
  - If A==32'h80000000 and B==32'hFFFFFFFF: go directly to DONE at N+1 with result=0, exception=1.
  - Otherwise the sequence is:
    - DNEG_A (N+1): ALU 0 sub A; Q <= A[31] ? alu_result : A.
    - DNEG_B (N+2): ALU 0 sub B; D <= B[31] ? alu_result : B.
    - R=0, then DSTEP for 32 cycles (N+3..N+34).
    - DFIX (N+35).
    - DONE (N+36).
  - Each DSTEP cycle:
    - Rs = {R[30:0], Q[31]}; ALU Rs sub D.
    - borrow = (~Rs[31] & D[31]) | (~(Rs[31]^D[31]) & alu_result[31]).
    - If borrow: R <= Rs, Q <= {Q[30:0],0}. Otherwise: R <= alu_result, Q <= {Q[30:0],1}.
  - DFIX: ALU 0 sub Q. Quotient = (A[31]^B[31]) ? alu_result : Q. Truncates toward zero; exception=0; remainder is discarded.
- Magnitude 0x80000000 is valid unsigned in the D and Q registers.
- In IDLE and DONE, alu_* outputs are driven to 0 (opcode add).

Test Plan:
- MULT: A=7, B=-6 pulsed at cycle N -> resultRDY at N+33 only; data_result=32'hFFFFFFD6 (-42), exception=0; busy high N+1..N+33.
- MULT: A=32'h80000000, B=32'h80000000 -> result=0, exception=1. A=32'h40000000, B=4 -> result=0, exception=1. A=-1, B=-1 -> result=1, exception=0.
- DIV: A=-7, B=2 -> resultRDY at N+36, result=-3 (32'hFFFFFFFD), exception=0. A=32'h80000000, B=1 -> result=32'h80000000, exception=0.
- DIV: B=0 -> resultRDY at N+1, result=0, exception=1. A=32'h80000000, B=-1 -> same response.
- ctrl_DIV pulsed at N+10 during a MULT -> ignored; only one resultRDY, at N+33. A new ctrl_MULT in the DONE cycle is accepted: next resultRDY 33 cycles later, with no IDLE gap.
- reset asserted at N+15 of a DIV -> next cycle: all outputs 0, busy=0, and no resultRDY afterwards. A fresh MULT then completes normally.
